h2f_sequencer: RTL and testbench
================================

H2F_SEQUENCER -- requirements
Module: h2f_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: busy-wait limit per command step, in cycles (used only when H2F_SEQ_TIMEOUT_EN is defined).
REQ-003 clock  in  1  system clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 core_reset_n  in  1  copied to h2f_value[31] (core reset, active low).
REQ-006 core_run  in  1  copied to h2f_value[30] (core run).
REQ-007 req_valid  in  1  transaction request.
REQ-008 req_ready  out  1  transaction accepted when req_valid && req_ready.
REQ-009 req_op  in  2  0=write inst RAM, 1=write data RAM, 2=read inst RAM, 3=read data RAM.
REQ-010 req_address  in  16  RAM byte address.
REQ-011 req_data  in  32  write data (ops 0/1 only).
REQ-012 rsp_valid  out  1  transaction complete; held until rsp_ready.
REQ-013 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-014 rsp_data  out  32  read result (ops 2/3); 0 for writes.
REQ-015 rsp_error  out  1  transaction aborted (timeout or run asserted).
REQ-016 h2f_value  out  32  command word to the host-bridge command decoder.
REQ-017 f2h_value  in  32  status word from that decoder: [29]=busy, [15:0]=data.

Function
REQ-018 h2f_value SHALL be {core_reset_n, core_run, request, 5'b0, cmd[7:0], param[15:0]}; request, cmd and param are registered.
REQ-019 req_ready SHALL be 1 only in IDLE with core_run==0 and rsp_valid==0.
REQ-020 On accept, all req_* fields SHALL be latched; later changes to them have no effect.
REQ-021 Write op SHALL issue the steps PUT_LOW(8'd0, data[15:0]), PUT_HIGH(8'd1, data[31:16]), then WRITE_INST(8'd2) or WRITE_DATA(8'd3) with param=address.
REQ-022 Read op SHALL issue READ_INST(8'd4) or READ_DATA(8'd5) with param=address, then GET_LOW(8'd9), then GET_HIGH(8'd10).
REQ-023 Each step SHALL follow ISSUE -> GAP -> WAIT.
REQ-024 ISSUE SHALL hold request=1 for exactly one cycle.
REQ-025 GAP SHALL hold request=0 for one cycle and SHALL NOT sample busy.
REQ-026 WAIT SHALL hold request=0 until f2h_value[29]==0, then advance to the next step.
REQ-027 Minimum step time SHALL be 3 cycles; minimum transaction time SHALL be 9 cycles from accept to rsp_valid.
REQ-028 In the WAIT that ends GET_LOW, f2h_value[15:0] SHALL be captured into rsp_data[15:0].
REQ-029 In the WAIT that ends GET_HIGH, f2h_value[15:0] SHALL be captured into rsp_data[31:16].
REQ-030 States SHALL be IDLE, ISSUE, GAP, WAIT, RESP, with a 2-bit step index 0..2.
REQ-031 After the final WAIT the block SHALL go to RESP with rsp_valid=1.
REQ-032 RESP -> IDLE SHALL occur on the cycle rsp_ready==1; req_ready may rise the following cycle.
REQ-033 If core_run==1 when a step would enter ISSUE, the block SHALL abort to RESP with rsp_error=1 and rsp_data=0, issuing no further commands.
REQ-034 request SHALL never be 1 while core_run==1.
REQ-035 core_reset_n and core_run SHALL pass to bits 31/30 combinationally in every state, including reset.

Reset
REQ-036 While reset_n==0, the block SHALL be in IDLE with request=0, cmd=0, param=0, rsp_valid=0, rsp_error=0, rsp_data=0, step=0 and the timeout counter=0.
REQ-037 Reset asserted mid-transaction SHALL drop the transaction with no response; request falls asynchronously.

Configuration
REQ-038 With H2F_SEQ_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to WAIT and increment on each WAIT cycle with busy==1.
REQ-039 With H2F_SEQ_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL go to RESP with rsp_error=1 and rsp_data=0.
REQ-040 Without H2F_SEQ_TIMEOUT_EN, WAIT SHALL wait indefinitely, rsp_error SHALL be set only per REQ-033, and no counter logic is present.

Verification
REQ-041 Write op=0, addr=16'h0010, data=32'hDEADBEEF, decoder model with 1-cycle busy -> h2f commands 0/BEEF, 1/DEAD, 2/0010; rsp_valid at cycle 9; rsp_error=0.
REQ-042 Read op=3, addr=16'h0020, model RAM word 32'h12345678 -> commands 5/0020, 9, 10; rsp_data=32'h12345678.
REQ-043 core_run=1 while req_valid=1 -> req_ready=0; request bit never asserted.
REQ-044 Timeout build, TIMEOUT_CYCLES=4, busy stuck at 1 -> rsp_error=1, rsp_data=0; next transaction accepted after rsp_ready.
REQ-045 reset_n pulsed low during the GET_LOW step -> h2f_value[29:0]=0 immediately; no rsp_valid; fresh write afterwards completes normally.
REQ-046 rsp_ready held 0 for 5 cycles after a read -> rsp_valid and rsp_data stable; req_ready=0 throughout.

Source files
------------

// File: rtl/h2f_sequencer_if.sv
// Request/response bus between a transaction master and h2f_sequencer.
//   slave  modport: sequencer side (accepts requests, returns responses)
//   master modport: requester side (issues requests, consumes responses)
// Signals:
//   req_valid/req_ready : request handshake
//   req_op              : 0=wr inst, 1=wr data, 2=rd inst, 3=rd data
//   req_address         : RAM byte address
//   req_data            : write data
//   rsp_valid/rsp_ready : response handshake
//   rsp_data            : read result (0 for writes and aborts)
//   rsp_error           : transaction aborted
interface h2f_sequencer_if;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;

    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic [ADDR_W-1:0] req_address;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_error;

    modport slave (
        input  req_valid, req_op, req_address, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_error
    );

    modport master (
        output req_valid, req_op, req_address, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_error
    );
endinterface

// File: rtl/h2f_sequencer.sv
// Host-to-FPGA command sequencer: turns one RAM read/write transaction into
// a series of command steps on the h2f/f2h word pair of the host-bridge
// command decoder. Each step is ISSUE (request pulse) -> GAP -> WAIT(!busy).
// Ports:
//   clock, reset_n      : clock, async active-low reset
//   core_reset_n        : passed to h2f_value[31]
//   core_run            : passed to h2f_value[30]; blocks and aborts commands
//   bus (slave)         : req_*/rsp_* transaction handshake
//   h2f_value           : {core_reset_n, core_run, request, 5'b0, cmd, param}
//   f2h_value           : decoder status, [29]=busy, [15:0]=data
// Optional feature: define H2F_SEQ_TIMEOUT_EN to abort a step whose WAIT sees
// busy for TIMEOUT_CYCLES cycles.
module h2f_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  core_reset_n,
    input  logic                  core_run,
    h2f_sequencer_if.slave        bus,
    output logic [31:0]           h2f_value,
    input  logic [31:0]           f2h_value
);
    localparam int unsigned CMD_W   = 8;
    localparam int unsigned PARAM_W = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STEP_W  = 2;
    localparam int unsigned TMO_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [1:0]           op_q, op_d;
    logic [PARAM_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 request_q, request_d;
    logic [CMD_W-1:0]     cmd_q, cmd_d;
    logic [PARAM_W-1:0]   param_q, param_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_error_q, rsp_error_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
`ifdef H2F_SEQ_TIMEOUT_EN
    logic [TMO_W-1:0]     tmo_q, tmo_d;
`endif

    logic busy;
    logic req_ready_c;
    logic unused_bits;

    assign busy = f2h_value[29];

`ifdef H2F_SEQ_TIMEOUT_EN
    assign unused_bits = ^{f2h_value[31:30], f2h_value[28:16]};
`else
    assign unused_bits = ^{f2h_value[31:30], f2h_value[28:16], 32'(TIMEOUT_CYCLES)};
`endif

    // Command word {cmd, param} for a given op and step index.
    function automatic logic [CMD_W+PARAM_W-1:0] step_word(
        input logic [1:0]         op,
        input logic [STEP_W-1:0]  step,
        input logic [PARAM_W-1:0] addr,
        input logic [DATA_W-1:0]  data
    );
        logic [CMD_W+PARAM_W-1:0] w;
        w = '0;
        if (!op[1]) begin
            case (step)
                2'd0:    w = {8'd0, data[15:0]};
                2'd1:    w = {8'd1, data[31:16]};
                default: w = {(op[0] ? 8'd3 : 8'd2), addr};
            endcase
        end else begin
            case (step)
                2'd0:    w = {(op[0] ? 8'd5 : 8'd4), addr};
                2'd1:    w = {8'd9, 16'd0};
                default: w = {8'd10, 16'd0};
            endcase
        end
        return w;
    endfunction

    assign req_ready_c     = (state_q == S_IDLE) && !core_run && !rsp_valid_q;
    assign bus.req_ready   = req_ready_c;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_error   = rsp_error_q;
    assign bus.rsp_data    = rsp_data_q;

    // Request is masked by core_run so it can never be seen high while the core runs.
    assign h2f_value = {core_reset_n, core_run, request_q & ~core_run, 5'b0, cmd_q, param_q};

    // Next-state and datapath logic.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        request_d   = 1'b0;
        cmd_d       = cmd_q;
        param_d     = param_q;
        rsp_valid_d = rsp_valid_q;
        rsp_error_d = rsp_error_q;
        rsp_data_d  = rsp_data_q;
`ifdef H2F_SEQ_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_c) begin
                    op_d             = bus.req_op;
                    addr_d           = bus.req_address;
                    data_d           = bus.req_data;
                    step_d           = '0;
                    rsp_data_d       = '0;
                    rsp_error_d      = 1'b0;
                    request_d        = 1'b1;
                    {cmd_d, param_d} = step_word(bus.req_op, 2'd0, bus.req_address, bus.req_data);
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_GAP;
            end
            S_GAP: begin
`ifdef H2F_SEQ_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!busy) begin
                    if (op_q[1] && step_q == 2'd1) begin
                        rsp_data_d[15:0] = f2h_value[15:0];
                    end
                    if (op_q[1] && step_q == 2'd2) begin
                        rsp_data_d[31:16] = f2h_value[15:0];
                    end
                    if (step_q == 2'd2) begin
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else if (core_run) begin
                        // Abort instead of entering ISSUE; partial read data is discarded.
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_data_d  = '0;
                        state_d     = S_RESP;
                    end else begin
                        step_d           = step_q + 2'd1;
                        request_d        = 1'b1;
                        {cmd_d, param_d} = step_word(op_q, step_q + 2'd1, addr_q, data_q);
                        state_d          = S_ISSUE;
                    end
                end
`ifdef H2F_SEQ_TIMEOUT_EN
                else begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_q + 8'd1 == TMO_W'(TIMEOUT_CYCLES)) begin
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_data_d  = '0;
                        state_d     = S_RESP;
                    end
                end
`endif
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    step_d      = '0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            request_q   <= 1'b0;
            cmd_q       <= '0;
            param_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef H2F_SEQ_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            request_q   <= request_d;
            cmd_q       <= cmd_d;
            param_q     <= param_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_data_q  <= rsp_data_d;
`ifdef H2F_SEQ_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end
endmodule

// File: tb/tb_h2f_sequencer.sv
// Self-checking bench for h2f_sequencer: a command-decoder/RAM model answers
// the h2f/f2h protocol, and a scoreboard RAM predicts read data.
module tb_h2f_sequencer;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        core_reset_n;
    logic        core_run;
    logic [31:0] h2f_value;
    logic [31:0] f2h_value;

    h2f_sequencer_if bus();

    h2f_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .core_reset_n (core_reset_n),
        .core_run     (core_run),
        .bus          (bus),
        .h2f_value    (h2f_value),
        .f2h_value    (f2h_value)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int viol   = 0;

    // Decoder / RAM device model.
    logic [31:0] dev_inst [int];
    logic [31:0] dev_data [int];
    logic [15:0] dev_lo = '0, dev_hi = '0, dev_dout = '0;
    logic [31:0] dev_rd = '0;
    int          busy_cnt = 0;
    int          busy_len = 1;
    logic        stuck = 1'b0;
    logic [23:0] cmd_log [$];

    assign f2h_value = {2'b00, (stuck || busy_cnt != 0), 13'd0, dev_dout};

    always @(posedge clock) begin
        if (h2f_value[29] && core_run) viol++;
        if (h2f_value[29]) begin
            cmd_log.push_back(h2f_value[23:0]);
            busy_cnt <= busy_len;
            case (h2f_value[23:16])
                8'd0:  dev_lo <= h2f_value[15:0];
                8'd1:  dev_hi <= h2f_value[15:0];
                8'd2:  dev_inst[int'(h2f_value[15:0])] = {dev_hi, dev_lo};
                8'd3:  dev_data[int'(h2f_value[15:0])] = {dev_hi, dev_lo};
                8'd4:  dev_rd <= dev_inst.exists(int'(h2f_value[15:0])) ? dev_inst[int'(h2f_value[15:0])] : 32'd0;
                8'd5:  dev_rd <= dev_data.exists(int'(h2f_value[15:0])) ? dev_data[int'(h2f_value[15:0])] : 32'd0;
                8'd9:  dev_dout <= dev_rd[15:0];
                8'd10: dev_dout <= dev_rd[31:16];
                default: ;
            endcase
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    // Scoreboard RAM.
    logic [31:0] ref_inst [int];
    logic [31:0] ref_data [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected command of step i: {cmd, param}; param is don't-care for GET steps.
    function automatic logic [23:0] exp_cmd(input logic [1:0] op, input logic [15:0] addr,
                                            input logic [31:0] data, input int i);
        case (op)
            2'd0: exp_cmd = (i == 0) ? {8'd0, data[15:0]} : (i == 1) ? {8'd1, data[31:16]} : {8'd2, addr};
            2'd1: exp_cmd = (i == 0) ? {8'd0, data[15:0]} : (i == 1) ? {8'd1, data[31:16]} : {8'd3, addr};
            2'd2: exp_cmd = (i == 0) ? {8'd4, addr} : (i == 1) ? {8'd9, 16'd0} : {8'd10, 16'd0};
            default: exp_cmd = (i == 0) ? {8'd5, addr} : (i == 1) ? {8'd9, 16'd0} : {8'd10, 16'd0};
        endcase
    endfunction

    task automatic start_txn(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] data, input int blen);
        @(negedge clock);
        busy_len = blen;
        cmd_log.delete();
        bus.req_valid   = 1'b1;
        bus.req_op      = op;
        bus.req_address = addr;
        bus.req_data    = data;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clock);
        #1;
        bus.req_valid   = 1'b0;
        bus.req_op      = 2'($urandom);
        bus.req_address = 16'($urandom);
        bus.req_data    = $urandom;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!bus.rsp_valid && cyc < 300) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        if (cyc >= 300) chk("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic finish_rsp(input int rdelay);
        logic [31:0] held;
        held = bus.rsp_data;
        for (int k = 0; k < rdelay; k++) begin
            @(posedge clock);
            #1;
            chk("rsp_valid_held", 32'(bus.rsp_valid), 32'd1);
            chk("rsp_data_held", bus.rsp_data, held);
            chk("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clock);
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic run_txn(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] data,
                           input int blen, input int rdelay);
        int cyc;
        logic [31:0] exp_data;
        start_txn(op, addr, data, blen);
        wait_rsp(cyc);
        chk("latency", 32'(cyc), 32'(3 * (blen + 2)));
        exp_data = 32'd0;
        case (op)
            2'd0: ref_inst[int'(addr)] = data;
            2'd1: ref_data[int'(addr)] = data;
            2'd2: exp_data = ref_inst.exists(int'(addr)) ? ref_inst[int'(addr)] : 32'd0;
            default: exp_data = ref_data.exists(int'(addr)) ? ref_data[int'(addr)] : 32'd0;
        endcase
        chk("rsp_error", 32'(bus.rsp_error), 32'd0);
        chk("rsp_data", bus.rsp_data, exp_data);
        chk("cmd_count", 32'(cmd_log.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < cmd_log.size()) begin
                if (op[1] && i > 0) chk("cmd_code", 32'(cmd_log[i][23:16]), 32'(exp_cmd(op, addr, data, i) >> 16));
                else                chk("cmd_word", 32'(cmd_log[i]), 32'(exp_cmd(op, addr, data, i)));
            end
        end
        finish_rsp(rdelay);
    endtask

    initial begin
        int cyc;
        int seen;
        bus.req_valid   = 1'b0;
        bus.req_op      = '0;
        bus.req_address = '0;
        bus.req_data    = '0;
        bus.rsp_ready   = 1'b0;
        reset_n         = 1'b0;
        core_reset_n    = 1'b0;
        core_run        = 1'b1;
        #1;
        chk("rst_h2f_top", 32'(h2f_value[31:30]), 32'd1);
        chk("rst_h2f_low", 32'(h2f_value[29:0]), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        core_reset_n = 1'b1;
        core_run     = 1'b0;
        #1;
        chk("rst_h2f_top2", 32'(h2f_value[31:30]), 32'd2);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed write and read, then a held-off response.
        run_txn(2'd0, 16'h0010, 32'hDEADBEEF, 1, 0);
        run_txn(2'd1, 16'h0020, 32'h12345678, 1, 0);
        run_txn(2'd3, 16'h0020, 32'h0, 1, 0);
        run_txn(2'd2, 16'h0010, 32'h0, 2, 5);
        run_txn(2'd3, 16'h0020, 32'h0, 1, 5);

        // Random traffic.
        for (int n = 0; n < 14; n++) begin
            run_txn(2'($urandom_range(0, 3)), 16'($urandom_range(0, 7) * 4), $urandom,
                    $urandom_range(1, 3), $urandom_range(0, 3));
        end

        // core_run blocks acceptance and requests.
        @(negedge clock);
        cmd_log.delete();
        core_run        = 1'b1;
        bus.req_valid   = 1'b1;
        bus.req_op      = 2'd0;
        bus.req_address = 16'h0040;
        bus.req_data    = 32'hCAFEF00D;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            chk("run_req_ready", 32'(bus.req_ready), 32'd0);
            chk("run_h2f_req", 32'(h2f_value[30:29]), 32'd2);
        end
        @(negedge clock);
        bus.req_valid = 1'b0;
        core_run      = 1'b0;
        chk("run_no_cmds", 32'(cmd_log.size()), 32'd0);
        chk("run_no_rsp", 32'(bus.rsp_valid), 32'd0);

        // core_run raised during the GET_LOW wait aborts the read.
        start_txn(2'd3, 16'h0020, 32'h0, 2);
        repeat (5) @(posedge clock);
        #1;
        core_run = 1'b1;
        wait_rsp(cyc);
        chk("abort_error", 32'(bus.rsp_error), 32'd1);
        chk("abort_data", bus.rsp_data, 32'd0);
        chk("abort_cmds", 32'(cmd_log.size()), 32'd2);
        core_run = 1'b0;
        finish_rsp(1);

`ifdef H2F_SEQ_TIMEOUT_EN
        // Busy stuck high: step aborts after TIMEOUT_CYCLES busy WAIT cycles.
        stuck = 1'b1;
        start_txn(2'd0, 16'h0100, 32'hA5A5A5A5, 1);
        wait_rsp(cyc);
        chk("tmo_latency", 32'(cyc), 32'd6);
        chk("tmo_error", 32'(bus.rsp_error), 32'd1);
        chk("tmo_data", bus.rsp_data, 32'd0);
        chk("tmo_cmds", 32'(cmd_log.size()), 32'd1);
        stuck = 1'b0;
        finish_rsp(0);
`else
        // Busy stuck high: no timeout, completes once busy clears.
        stuck = 1'b1;
        start_txn(2'd0, 16'h0100, 32'hA5A5A5A5, 1);
        repeat (30) @(posedge clock);
        #1;
        chk("stuck_waiting", 32'(bus.rsp_valid), 32'd0);
        @(negedge clock);
        stuck = 1'b0;
        wait_rsp(cyc);
        ref_inst[int'(16'h0100)] = 32'hA5A5A5A5;
        chk("stuck_error", 32'(bus.rsp_error), 32'd0);
        chk("stuck_cmds", 32'(cmd_log.size()), 32'd3);
        finish_rsp(0);
`endif
        run_txn(2'd2, 16'h0100, 32'h0, 1, 0);

        // Reset pulse while GET_LOW is being issued.
        start_txn(2'd3, 16'h0020, 32'h0, 1);
        repeat (3) @(posedge clock);
        #2;
        chk("pre_rst_req", 32'(h2f_value[29]), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_h2f", 32'(h2f_value[29:0]), 32'd0);
        chk("mid_rst_rsp", 32'(bus.rsp_valid), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clock);
            #1;
            if (bus.rsp_valid) seen++;
        end
        chk("post_rst_no_rsp", 32'(seen), 32'd0);
        run_txn(2'd1, 16'h0030, 32'h0BADCAFE, 1, 0);
        run_txn(2'd3, 16'h0030, 32'h0, 1, 0);

        chk("request_while_run", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
